gated_acc_ctrl: RTL and testbench

Controller for one neuron's 15-bit split accumulator in the Binary MLP datapath. It accepts signed partial sums (XNOR-popcount terms) through a valid/ready stream and computes the next accumulator value. It drives the upper-byte clock-gate enable, so bits [14:7] are clocked only when they actually change, while bits [6:0] are clocked every cycle. After a programmed number of terms it presents the final sum on a valid/ready output.

---
 rtl/bmlp_pkg.sv | 16 +
 rtl/gated_acc_ctrl.sv | 117 +++++++++++
 tb/tb_gated_acc_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bmlp_pkg.sv
// Shared types and widths for the Binary MLP neuron datapath.
package bmlp_pkg;

    localparam int ACC_W   = 15;
    localparam int LO_W    = 7;
    localparam int TERM_DW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_SETTLE,
        S_DONE
    } acc_state_t;

endpackage

// File: rtl/gated_acc_ctrl.sv
// Split-accumulator controller: computes the next accumulator value, drives the
// upper-slice clock-gate enable, counts terms and hands off the final sum.
module gated_acc_ctrl #(
    parameter int TERM_W = 10,
    parameter int ACC_W  = bmlp_pkg::ACC_W,
    parameter int LO_W   = bmlp_pkg::LO_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [TERM_W-1:0]            num_terms,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [bmlp_pkg::TERM_DW-1:0] in_data,
    input  logic [ACC_W-1:0]             acc_q,
    output logic [ACC_W-1:0]             acc_d,
    output logic                         hi_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_data,
    output logic                         ovf,
    output logic                         busy
);
    import bmlp_pkg::*;

    acc_state_t        state_q, state_d;
    logic [TERM_W-1:0] cnt_q, cnt_d;
    logic [TERM_W-1:0] num_q, num_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic [ACC_W-1:0]  term_ext;
    logic [ACC_W-1:0]  sum;
    logic              sum_ovf;

    assign in_ready = (state_q == S_ACCUM) && !rst;
    assign accept   = in_ready && in_valid;
    assign term_ext = {{(ACC_W-TERM_DW){in_data[TERM_DW-1]}}, in_data};

    // Next accumulator value, overflow detect and upper-slice change detect.
    // Reset and CLEAR force both slices to load zero through the gate.
    always_comb begin
        sum     = acc_q + term_ext;
        sum_ovf = (acc_q[ACC_W-1] == term_ext[ACC_W-1]) &&
                  (sum[ACC_W-1] != acc_q[ACC_W-1]);
        acc_d   = acc_q;
        if (rst || state_q == S_CLEAR)
            acc_d = '0;
        else if (accept)
            acc_d = sum;
        hi_en = (acc_d[ACC_W-1:LO_W] != acc_q[ACC_W-1:LO_W]);
        if (rst || state_q == S_CLEAR)
            hi_en = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_terms;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = (num_q != '0) ? S_ACCUM : S_SETTLE;
            S_ACCUM: begin
                if (in_valid) begin
                    cnt_d = cnt_q + TERM_W'(1);
                    if (sum_ovf)
                        ovf_d = 1'b1;
                    if (cnt_q == num_q - TERM_W'(1))
                        state_d = S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_DONE;
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
        // Status flags are registered from the next state so they line up with it.
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            num_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gated_acc_ctrl.sv
// Bench for gated_acc_ctrl: models the external split register and compares
// against an arithmetic reference of the running sum.
module tb_gated_acc_ctrl;

    localparam int TERM_W = 10;
    localparam int NOLIT  = -99999;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [TERM_W-1:0] num_terms = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = '0;
    logic [14:0]       acc_q, acc_d, out_data;
    logic              hi_en, out_valid, ovf, busy;
    logic              out_ready = 1'b0;

    logic [6:0]        lo_r;
    logic [7:0]        hi_r;

    int checks = 0;
    int failures = 0;
    int hi_cnt = 0;
    int terms[$];

    always #5 clk = ~clk;

    gated_acc_ctrl #(.TERM_W(TERM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .acc_q(acc_q), .acc_d(acc_d), .hi_en(hi_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ovf(ovf), .busy(busy)
    );

    // External split register: low slice always clocked, high slice gated.
    always @(posedge clk) begin
        lo_r <= acc_d[6:0];
        if (hi_en) hi_r <= acc_d[14:7];
    end
    assign acc_q = {hi_r, lo_r};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int wrap15(input int v);
        int m;
        m = v & 32'h7FFF;
        return (m >= 16384) ? m - 32768 : m;
    endfunction

    // Every accepted beat: next value is the wrapped sum, gate opens only if the upper byte moves.
    always @(negedge clk) begin
        if (!rst && hi_en) hi_cnt++;
        if (!rst && in_valid && in_ready) begin
            int e;
            e = (int'(acc_q) + int'($signed(in_data))) & 32'h7FFF;
            chk("beat_acc_d", 32'(acc_d), e);
            chk("beat_hi_en", 32'(hi_en), 32'((e >> 7) != (int'(acc_q) >> 7)));
        end
    end

    task automatic run_txn(input string tag, input int n, input int gap_pct, input int hold,
                           input bit poke_start, input int exp_hi, input int lit, input int lit_ovf);
        int  r = 0;
        bit  ov = 0;
        int  idx = 0;
        int  cyc = 0;
        int  lat = 0;
        int  hi0;
        int  exp_sum;
        foreach (terms[i]) begin
            r += terms[i];
            if (r > 16383 || r < -16384) ov = 1;
            r = wrap15(r);
        end
        exp_sum = r & 32'h7FFF;
        hi0 = hi_cnt;
        @(posedge clk); #1 start = 1'b1; num_terms = n[TERM_W-1:0];
        @(negedge clk); chk({tag, "_idle_busy"}, 32'(busy), 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk({tag, "_clear_busy"}, 32'(busy), 1);
        chk({tag, "_clear_ovf"}, 32'(ovf), 0);
        chk({tag, "_clear_hi_en"}, 32'(hi_en), 1);
        while (idx < n && cyc < 5000) begin
            @(posedge clk); #1
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = terms[idx][7:0];
            @(negedge clk);
            cyc++;
            if (in_valid && in_ready) idx++;
        end
        if (idx < n) chk({tag, "_feed_timeout"}, idx, n);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        chk({tag, "_out_latency"}, lat, 2);
        #1;
        chk({tag, "_out_data"}, 32'(out_data), exp_sum);
        chk({tag, "_ovf"}, 32'(ovf), 32'(ov));
        if (exp_hi >= 0) chk({tag, "_hi_en_count"}, hi_cnt - hi0, exp_hi);
        if (lit != NOLIT) chk({tag, "_out_lit"}, 32'(out_data), lit & 32'h7FFF);
        if (lit_ovf >= 0) chk({tag, "_ovf_lit"}, 32'(ovf), lit_ovf);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1 start = poke_start;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 1);
            chk({tag, "_hold_data"}, 32'(out_data), exp_sum);
        end
        @(posedge clk); #1 start = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk({tag, "_done_valid"}, 32'(out_valid), 1);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_valid"}, 32'(out_valid), 0);
        chk({tag, "_idle_busy2"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_acc_d", 32'(acc_d), 0);
        chk("rst_hi_en", 32'(hi_en), 1);
        chk("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_acc_q", 32'(acc_q), 0);

        terms = '{5, 10, -3};
        run_txn("t_small", 3, 0, 0, 0, 1, 12, 0);
        terms = '{100, 50};
        run_txn("t_carry", 2, 0, 0, 0, 2, 150, 0);
        terms = '{10, -20};
        run_txn("t_borrow", 2, 0, 0, 0, 2, 32'h7FF6, 0);
        terms.delete();
        run_txn("t_zero", 0, 0, 5, 1, 1, 0, 0);
        terms.delete();
        for (int i = 0; i < 130; i++) terms.push_back(127);
        run_txn("t_ovf", 130, 30, 0, 0, -1, 16510, 1);

        // Reset in the middle of an accumulation.
        @(posedge clk); #1 start = 1'b1; num_terms = 10'd5;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 in_valid = 1'b1; in_data = 8'd7;
        @(posedge clk); #1 in_data = 8'd8;
        @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_acc_d", 32'(acc_d), 0);
        chk("mid_rst_hi_en", 32'(hi_en), 1);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_acc_d", 32'(acc_d), 0);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_no_out", 32'(out_valid), 0);
        end
        terms = '{1, 2};
        run_txn("t_after_rst", 2, 0, 0, 0, 1, 3, 0);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(40, 1);
            terms.delete();
            for (int i = 0; i < n; i++) terms.push_back(int'($urandom_range(255)) - 128);
            run_txn("t_rand", n, 25, $urandom_range(3), 1'($urandom_range(1)), -1, NOLIT, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
